r_return_mux: RTL and testbench

//  Downstream consumer of the per-slave R-channel FIFOs in the crossbar. Arbitrates

---
 rtl/r_return_mux.sv | 185 ++++++++++++++++++
 tb/tb_r_return_mux.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_return_mux.sv
// -----------------------------------------------------------------------------
// r_return_mux
//   Merges the fronts of NUM_SRC per-slave R-channel FIFOs onto one master R
//   channel. It pops at most one FIFO per cycle into a registered output stage
//   that uses an AXI VALID/READY handshake. A source that still has beats
//   pending is picked round-robin, starting after the last source granted.
//
// Configuration macro: R_MUX_BURST_LOCK_EN
//   defined   : the grant stays on one source from the first beat of a burst
//               through its RLAST beat, so bursts are never interleaved.
//   undefined : every beat is arbitrated, so beats from different sources
//               interleave. RLAST is passed through unchanged.
//
// Ports
//   ACLK, ARESETn        clock and synchronous active-low reset
//   src_empty[i]         FIFO i empty flag
//   src_RID/RDATA/RRESP  FIFO front payload, slice i belongs to source i
//   src_RLAST[i]         FIFO i front RLAST
//   src_pop[i]           combinational one-hot pop strobe back to FIFO i
//   RID/RDATA/RRESP/RLAST registered master R payload
//   RVALID / RREADY      master R handshake
//   grant_idx            source of the beat held in the output register
// -----------------------------------------------------------------------------
module r_return_mux #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_SRC-1:0]            src_empty,
    input  logic [NUM_SRC*ID_WIDTH-1:0]   src_RID,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_RDATA,
    input  logic [NUM_SRC*2-1:0]          src_RRESP,
    input  logic [NUM_SRC-1:0]            src_RLAST,
    output logic [NUM_SRC-1:0]            src_pop,
    output logic [ID_WIDTH-1:0]           RID,
    output logic [DATA_WIDTH-1:0]         RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [$clog2(NUM_SRC)-1:0]    grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    // Output register and arbitration state
    logic                  rvalid_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      rr_ptr_q;

    // Selected FIFO front, i.e. the next value of the output register on load
    logic [ID_WIDTH-1:0]   rid_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]            rresp_d;
    logic                  rlast_d;

    logic [IDX_W-1:0]      rr_sel;
    logic                  rr_found;
    logic [IDX_W-1:0]      rr_cand;
    logic [IDX_W-1:0]      sel;
    logic                  load;

`ifdef R_MUX_BURST_LOCK_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] lock_idx_q;
`endif

    // Round-robin search: first non-empty source strictly after rr_ptr, wrapping.
    // If every source is empty, rr_sel falls back to rr_ptr, which is empty too,
    // so no load can happen.
    always_comb begin
        rr_sel   = rr_ptr_q;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            rr_cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!rr_found && !src_empty[rr_cand]) begin
                rr_sel   = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    // A locked burst pins the selection even when its FIFO is momentarily empty
`ifdef R_MUX_BURST_LOCK_EN
    assign sel = (state_q == ST_LOCK) ? lock_idx_q : rr_sel;
`else
    assign sel = rr_sel;
`endif

    // Payload mux for the selected source
    always_comb begin
        rid_d   = '0;
        rdata_d = '0;
        rresp_d = '0;
        rlast_d = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel == IDX_W'(i)) begin
                rid_d   = src_RID[i*ID_WIDTH +: ID_WIDTH];
                rdata_d = src_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
                rresp_d = src_RRESP[i*2 +: 2];
                rlast_d = src_RLAST[i];
            end
        end
    end

    // Load when the output slot is free or being drained this cycle; held off in
    // reset so the FIFOs are never popped while everything is being cleared.
    assign load = ARESETn & (~rvalid_q | RREADY) & ~src_empty[sel];

    // One-hot pop strobe, same cycle as the load
    always_comb begin
        src_pop = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_pop[i] = load && (sel == IDX_W'(i));
        end
    end

    // Output register, round-robin pointer and burst-lock state
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
            grant_q    <= '0;
            rr_ptr_q   <= LAST_IDX;
`ifdef R_MUX_BURST_LOCK_EN
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
`endif
        end else begin
            if (load) begin
                rvalid_q <= 1'b1;
                rid_q    <= rid_d;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
                rlast_q  <= rlast_d;
                grant_q  <= sel;
                // While locked sel already equals rr_ptr, so this only moves on
                // an arbitrated beat.
                rr_ptr_q <= sel;
`ifdef R_MUX_BURST_LOCK_EN
                case (state_q)
                    ST_IDLE: begin
                        if (!rlast_d) begin
                            state_q    <= ST_LOCK;
                            lock_idx_q <= sel;
                        end
                    end
                    ST_LOCK: begin
                        if (rlast_d) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
`endif
            end else if (RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign RVALID    = rvalid_q;
    assign RID       = rid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign RLAST     = rlast_q;
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_r_return_mux.sv
// -----------------------------------------------------------------------------
// tb_r_return_mux
//   Directed bench for r_return_mux with NUM_SRC=2. Two queues stand in for the
//   source FIFOs; the bench pops them whenever src_pop was high at a clock edge.
//   Expected values are hand-derived per step. Burst-order expectations follow
//   the R_MUX_BURST_LOCK_EN setting.
// -----------------------------------------------------------------------------
module tb_r_return_mux;

    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned DATA_W  = 32;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    logic                       ACLK = 1'b0;
    logic                       ARESETn;
    logic [NUM_SRC-1:0]         src_empty;
    logic [NUM_SRC*ID_W-1:0]    src_RID;
    logic [NUM_SRC*DATA_W-1:0]  src_RDATA;
    logic [NUM_SRC*2-1:0]       src_RRESP;
    logic [NUM_SRC-1:0]         src_RLAST;
    logic [NUM_SRC-1:0]         src_pop;
    logic [ID_W-1:0]            RID;
    logic [DATA_W-1:0]          RDATA;
    logic [1:0]                 RRESP;
    logic                       RLAST;
    logic                       RVALID;
    logic                       RREADY;
    logic [0:0]                 grant_idx;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    beat_t q0[$];
    beat_t q1[$];

    r_return_mux #(
        .NUM_SRC    (NUM_SRC),
        .ID_WIDTH   (ID_W),
        .DATA_WIDTH (DATA_W)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .src_empty (src_empty),
        .src_RID   (src_RID),
        .src_RDATA (src_RDATA),
        .src_RRESP (src_RRESP),
        .src_RLAST (src_RLAST),
        .src_pop   (src_pop),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .grant_idx (grant_idx)
    );

    always #5 ACLK = ~ACLK;

    function automatic beat_t mk(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data,
                                 input logic [1:0] resp, input logic last);
        beat_t b;
        b.id   = id;
        b.data = data;
        b.resp = resp;
        b.last = last;
        return b;
    endfunction

    // Present the queue fronts on the FIFO-side inputs
    task automatic drive_fronts();
        src_empty[0] = (q0.size() == 0);
        src_empty[1] = (q1.size() == 0);
        src_RID      = '0;
        src_RDATA    = '0;
        src_RRESP    = '0;
        src_RLAST    = '0;
        if (q0.size() != 0) begin
            src_RID[3:0]     = q0[0].id;
            src_RDATA[31:0]  = q0[0].data;
            src_RRESP[1:0]   = q0[0].resp;
            src_RLAST[0]     = q0[0].last;
        end
        if (q1.size() != 0) begin
            src_RID[7:4]     = q1[0].id;
            src_RDATA[63:32] = q1[0].data;
            src_RRESP[3:2]   = q1[0].resp;
            src_RLAST[1]     = q1[0].last;
        end
    endtask

    task automatic settle();
        drive_fronts();
        #1;
    endtask

    // One clock: pop what the DUT strobed, then refresh the fronts
    task automatic tick();
        logic [1:0] pop;
        pop = src_pop;
        @(posedge ACLK);
        if (pop[0] && q0.size() != 0) void'(q0.pop_front());
        if (pop[1] && q1.size() != 0) void'(q1.pop_front());
        #1;
        drive_fronts();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the pop strobe and output register for this cycle, then advance
    task automatic cyc(input string tag, input logic [1:0] ep, input logic ev,
                       input logic [31:0] ed, input logic eg);
        chk({tag, ".pop"}, 32'(src_pop), 32'(ep));
        chk({tag, ".valid"}, 32'(RVALID), 32'(ev));
        if (ev) begin
            chk({tag, ".data"}, RDATA, ed);
            chk({tag, ".grant"}, 32'(grant_idx), 32'(eg));
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for three cycles
        ARESETn = 1'b0;
        RREADY  = 1'b0;
        drive_fronts();
        repeat (3) tick();
        chk("rst.valid", 32'(RVALID), 32'h0);
        chk("rst.pop",   32'(src_pop), 32'h0);
        chk("rst.rid",   32'(RID), 32'h0);
        chk("rst.rdata", RDATA, 32'h0);
        chk("rst.rresp", 32'(RRESP), 32'h0);
        chk("rst.rlast", 32'(RLAST), 32'h0);
        chk("rst.grant", 32'(grant_idx), 32'h0);

        // Single beat: pop at t, visible at t+1, gone at t+2
        ARESETn = 1'b1;
        RREADY  = 1'b1;
        q0.push_back(mk(4'h3, 32'hDEADBEEF, 2'b00, 1'b1));
        settle();
        cyc("t2.t0", 2'b01, 1'b0, 32'h0, 1'b0);
        chk("t2.rid",   32'(RID), 32'h3);
        chk("t2.rlast", 32'(RLAST), 32'h1);
        cyc("t2.t1", 2'b00, 1'b1, 32'hDEADBEEF, 1'b0);
        cyc("t2.t2", 2'b00, 1'b0, 32'h0, 1'b0);

        // Backpressure: payload stable, no pops; release gives back-to-back beat
        RREADY = 1'b0;
        q0.push_back(mk(4'h1, 32'h11111111, 2'b00, 1'b1));
        q0.push_back(mk(4'h2, 32'h22222222, 2'b01, 1'b1));
        settle();
        cyc("t3.load", 2'b01, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("t3.stall", 2'b00, 1'b1, 32'h11111111, 1'b0);
        RREADY = 1'b1;
        settle();
        cyc("t3.resume", 2'b01, 1'b1, 32'h11111111, 1'b0);
        chk("t3.rresp", 32'(RRESP), 32'h1);
        chk("t3.rid",   32'(RID), 32'h2);
        cyc("t3.next", 2'b00, 1'b1, 32'h22222222, 1'b0);
        cyc("t3.drain", 2'b00, 1'b0, 32'h0, 1'b0);

        // Bursts with src0 running dry mid-burst while src1 has data
        q0.push_back(mk(4'h1, 32'hC0, 2'b00, 1'b0));
        q0.push_back(mk(4'h1, 32'hC1, 2'b00, 1'b0));
        settle();
        cyc("t4.a", 2'b01, 1'b0, 32'h0, 1'b0);
        q1.push_back(mk(4'h2, 32'hD0, 2'b00, 1'b0));
        q1.push_back(mk(4'h2, 32'hD1, 2'b00, 1'b1));
        settle();
`ifdef R_MUX_BURST_LOCK_EN
        cyc("t4.b", 2'b01, 1'b1, 32'hC0, 1'b0);
        cyc("t4.c", 2'b00, 1'b1, 32'hC1, 1'b0);
        cyc("t4.d", 2'b00, 1'b0, 32'h0, 1'b0);
        cyc("t4.e", 2'b00, 1'b0, 32'h0, 1'b0);
        q0.push_back(mk(4'h1, 32'hC2, 2'b00, 1'b0));
        q0.push_back(mk(4'h1, 32'hC3, 2'b00, 1'b1));
        settle();
        cyc("t4.f", 2'b01, 1'b0, 32'h0, 1'b0);
        cyc("t4.g", 2'b01, 1'b1, 32'hC2, 1'b0);
        chk("t4.c3last", 32'(RLAST), 32'h1);
        cyc("t4.h", 2'b10, 1'b1, 32'hC3, 1'b0);
        cyc("t4.i", 2'b10, 1'b1, 32'hD0, 1'b1);
        chk("t4.d1last", 32'(RLAST), 32'h1);
        cyc("t4.j", 2'b00, 1'b1, 32'hD1, 1'b1);
        cyc("t4.k", 2'b00, 1'b0, 32'h0, 1'b0);
`else
        cyc("t4.b", 2'b10, 1'b1, 32'hC0, 1'b0);
        chk("t4.d0last", 32'(RLAST), 32'h0);
        cyc("t4.c", 2'b01, 1'b1, 32'hD0, 1'b1);
        cyc("t4.d", 2'b10, 1'b1, 32'hC1, 1'b0);
        chk("t4.d1last", 32'(RLAST), 32'h1);
        cyc("t4.e", 2'b00, 1'b1, 32'hD1, 1'b1);
        cyc("t4.f", 2'b00, 1'b0, 32'h0, 1'b0);
`endif

        // Reset in the middle of a src1 burst
        for (int i = 0; i < 4; i++) q1.push_back(mk(4'h7, 32'(32'hE0 + i), 2'b00, i == 3));
        settle();
        cyc("t6.r1", 2'b10, 1'b0, 32'h0, 1'b0);
        cyc("t6.r2", 2'b10, 1'b1, 32'hE0, 1'b1);
        cyc("t6.r3", 2'b10, 1'b1, 32'hE1, 1'b1);
        ARESETn = 1'b0;
        settle();
        chk("t6.rstpop", 32'(src_pop), 32'h0);
        tick();
        q0.delete();
        q1.delete();
        settle();
        chk("t6.valid", 32'(RVALID), 32'h0);
        chk("t6.rdata", RDATA, 32'h0);
        chk("t6.rid",   32'(RID), 32'h0);
        chk("t6.rlast", 32'(RLAST), 32'h0);
        chk("t6.grant", 32'(grant_idx), 32'h0);
        ARESETn = 1'b1;

        // Single-beat bursts from both sources: grant alternates from source 0
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(4'h5, 32'(32'hA0 + i), 2'b00, 1'b1));
            q1.push_back(mk(4'h6, 32'(32'hB0 + i), 2'b00, 1'b1));
        end
        settle();
        cyc("t5.f1", 2'b01, 1'b0, 32'h0, 1'b0);
        chk("t5.rid0", 32'(RID), 32'h5);
        for (int i = 0; i < 4; i++) begin
            cyc("t5.a", 2'b10, 1'b1, 32'(32'hA0 + i), 1'b0);
            cyc("t5.b", (i == 3) ? 2'b00 : 2'b01, 1'b1, 32'(32'hB0 + i), 1'b1);
        end
        cyc("t5.end", 2'b00, 1'b0, 32'h0, 1'b0);

        // Four-beat bursts from both sources at once
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(4'h8, 32'(32'h100 + i), 2'b00, i == 3));
            q1.push_back(mk(4'h9, 32'(32'h200 + i), 2'b00, i == 3));
        end
        settle();
        cyc("t5.i1", 2'b01, 1'b0, 32'h0, 1'b0);
`ifdef R_MUX_BURST_LOCK_EN
        for (int i = 0; i < 4; i++) begin
            chk("t5.klast", 32'(RLAST), 32'(i == 3));
            cyc("t5.k", (i == 3) ? 2'b10 : 2'b01, 1'b1, 32'(32'h100 + i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("t5.llast", 32'(RLAST), 32'(i == 3));
            cyc("t5.l", (i == 3) ? 2'b00 : 2'b10, 1'b1, 32'(32'h200 + i), 1'b1);
        end
`else
        for (int i = 0; i < 4; i++) begin
            chk("t5.klast", 32'(RLAST), 32'(i == 3));
            cyc("t5.k", 2'b10, 1'b1, 32'(32'h100 + i), 1'b0);
            chk("t5.llast", 32'(RLAST), 32'(i == 3));
            cyc("t5.l", (i == 3) ? 2'b00 : 2'b01, 1'b1, 32'(32'h200 + i), 1'b1);
        end
`endif
        cyc("t5.iend", 2'b00, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
